// File: rtl/sdl_scan.sv
// sdl_scan: iterated down-left board shift FSM; define SDL_RAY_EN for the ray output and its accumulator
module sdl_scan #(
  parameter logic FILL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [2:0]  steps,
  output logic [31:0] A_shifted,
  output logic        busy,
`ifdef SDL_RAY_EN
  output logic [31:0] ray,
`endif
  output logic        done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [31:0] KEEP   = 32'h7777_7770;
  localparam logic [31:0] BORDER = 32'h8888_888F;
  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [31:0] work;
  logic [31:0] stepped;
`ifdef SDL_RAY_EN
  logic [31:0] acc;
`endif
  // one down-left step: square i takes square i-3, top row and right column get FILL
  always_comb stepped = ((work << 3) & KEEP) | ({32{FILL}} & BORDER);
  assign busy = state == SHIFT;
  assign done = state == DONE;
  // sequencing of load, shift steps and result capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      work      <= 32'd0;
      A_shifted <= 32'd0;
`ifdef SDL_RAY_EN
      acc       <= 32'd0;
      ray       <= 32'd0;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        work  <= A;
        cnt   <= steps;
        state <= (steps != 3'd0) ? SHIFT : DONE;
`ifdef SDL_RAY_EN
        acc   <= 32'd0;
        if (steps == 3'd0) ray <= 32'd0;
`endif
        if (steps == 3'd0) A_shifted <= A;
      end
    end else if (state == SHIFT) begin
      work <= stepped;
      cnt  <= cnt - 3'd1;
`ifdef SDL_RAY_EN
      acc  <= acc | stepped;
      if (cnt == 3'd1) ray <= acc | stepped;
`endif
      if (cnt == 3'd1) begin
        state     <= DONE;
        A_shifted <= stepped;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
